// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch sequencer: detects RAW hazards on branch sources, inserts 0-2 stalls,
// selects operand forwarding, drives PC redirect / IF/ID flush and keeps saturating stats.
module branch_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_branch,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             branch_sel,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic             pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_nxt;
  logic [1:0] rem, rem_nxt;
  logic       quiet_q;
  logic       quiet;

  logic [1:0] need_a, need_b, need;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  logic       do_stall;
  logic       do_resolve;
  logic       do_redirect;

  // x0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd == rs) && (rs != 5'd0);
  endfunction

  function automatic logic [1:0] stall_need(
    input logic [4:0] rs,
    input logic       e_we, input logic e_ld, input logic [4:0] e_rd,
    input logic       m_we, input logic m_ld, input logic [4:0] m_rd
  );
    if (hit(e_we, e_rd, rs))           return e_ld ? 2'd2 : 2'd1;
    else if (hit(m_we, m_rd, rs) && m_ld) return 2'd1;
    else                               return 2'd0;
  endfunction

  function automatic logic [1:0] fwd_pick(
    input logic [4:0] rs,
    input logic       m_we, input logic m_ld, input logic [4:0] m_rd,
    input logic       w_we, input logic [4:0] w_rd
  );
    if (hit(m_we, m_rd, rs) && !m_ld) return FWD_MEM;
    else if (hit(w_we, w_rd, rs))     return FWD_WB;
    else                              return FWD_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Outputs stay low during reset and for one cycle afterwards.
  assign quiet = reset || quiet_q;

  always_comb begin
    need_a    = stall_need(id_rs1, ex_regwrite, ex_memread, ex_rd,
                           mem_regwrite, mem_memread, mem_rd);
    need_b    = stall_need(id_rs2, ex_regwrite, ex_memread, ex_rd,
                           mem_regwrite, mem_memread, mem_rd);
    need      = (need_a > need_b) ? need_a : need_b;
    fwd_a_raw = fwd_pick(id_rs1, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
    fwd_b_raw = fwd_pick(id_rs2, mem_regwrite, mem_memread, mem_rd, wb_regwrite, wb_rd);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    rem_nxt     = rem;
    do_stall    = 1'b0;
    do_resolve  = 1'b0;
    do_redirect = 1'b0;

    if (quiet) begin
      state_nxt = IDLE;
      rem_nxt   = 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (id_branch) begin
            if (need == 2'd0) begin
              do_resolve  = 1'b1;
              do_redirect = branch_sel;
            end else begin
              do_stall  = 1'b1;
              rem_nxt   = need - 2'd1;
              state_nxt = (need == 2'd2) ? STALL : RESOLVE;
            end
          end
        end
        STALL: begin
          if (!id_branch) begin
            state_nxt = IDLE;
            rem_nxt   = 2'd0;
          end else begin
            do_stall  = 1'b1;
            rem_nxt   = (rem == 2'd0) ? 2'd0 : rem - 2'd1;
            state_nxt = (rem <= 2'd1) ? RESOLVE : STALL;
          end
        end
        RESOLVE: begin
          // Producers have advanced far enough that forwarding now covers them.
          state_nxt = IDLE;
          rem_nxt   = 2'd0;
          if (id_branch) begin
            do_resolve  = 1'b1;
            do_redirect = branch_sel;
          end
        end
        default: begin
          state_nxt = IDLE;
          rem_nxt   = 2'd0;
        end
      endcase
    end
  end

  assign stall_pc    = do_stall;
  assign stall_ifid  = do_stall;
  assign bubble_idex = do_stall;
  assign pc_sel      = do_redirect;
  assign flush_ifid  = do_redirect;
  assign fwd_a       = quiet ? FWD_RF : fwd_a_raw;
  assign fwd_b       = quiet ? FWD_RF : fwd_b_raw;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= 2'd0;
      quiet_q    <= 1'b1;
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      quiet_q <= 1'b0;
      if (do_resolve)               branch_cnt <= sat_inc(branch_cnt);
      if (do_resolve && branch_sel) taken_cnt  <= sat_inc(taken_cnt);
      if (do_stall)                 stall_cnt  <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: hazard stalls, forwarding, redirect, abandon,
// reset abort and counter saturation, with hand-computed expectations.
module tb_branch_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             id_branch;
  logic [4:0]       id_rs1, id_rs2;
  logic             ex_regwrite, ex_memread;
  logic [4:0]       ex_rd;
  logic             mem_regwrite, mem_memread;
  logic [4:0]       mem_rd;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic             branch_sel;
  logic             stall_pc, stall_ifid, bubble_idex, flush_ifid, pc_sel;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] branch_cnt, taken_cnt, stall_cnt;

  int tests;
  int fails;

  branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_branch    (id_branch),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .branch_sel   (branch_sel),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .bubble_idex  (bubble_idex),
    .flush_ifid   (flush_ifid),
    .pc_sel       (pc_sel),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .branch_cnt   (branch_cnt),
    .taken_cnt    (taken_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    id_branch    = 1'b0;
    id_rs1       = 5'd0;
    id_rs2       = 5'd0;
    ex_regwrite  = 1'b0;
    ex_memread   = 1'b0;
    ex_rd        = 5'd0;
    mem_regwrite = 1'b0;
    mem_memread  = 1'b0;
    mem_rd       = 5'd0;
    wb_regwrite  = 1'b0;
    wb_rd        = 5'd0;
    branch_sel   = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic e_stall, input logic e_pc,
                           input logic [1:0] e_fa, input logic [1:0] e_fb);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {stall_pc, stall_ifid, bubble_idex, pc_sel, flush_ifid, fwd_a, fwd_b};
    exp = {e_stall, e_stall, e_stall, e_pc, e_pc, e_fa, e_fb};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {stall3,pc,flush,fa,fb}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int e_b, input int e_t, input int e_s);
    logic [3*CNT_W-1:0] obs;
    logic [3*CNT_W-1:0] exp;
    obs = {branch_cnt, taken_cnt, stall_cnt};
    exp = {e_b[CNT_W-1:0], e_t[CNT_W-1:0], e_s[CNT_W-1:0]};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed b/t/s=%0d/%0d/%0d expected %0d/%0d/%0d",
             tag, branch_cnt, taken_cnt, stall_cnt, e_b, e_t, e_s);
    end
  endtask

  task automatic indep_branch(input logic sel);
    clear_pipe();
    id_branch  = 1'b1;
    id_rs1     = 5'd5;
    id_rs2     = 5'd6;
    branch_sel = sel;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_pipe();

    // Reset cycle: outputs masked even with a live hazard on the inputs.
    reset = 1'b1;
    id_branch = 1'b1; id_rs1 = 5'd9; ex_regwrite = 1'b1; ex_rd = 5'd9;
    mem_regwrite = 1'b1; mem_rd = 5'd9; branch_sel = 1'b1;
    #1;
    check_out("reset_cycle_outputs", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();

    // Cycle after reset: still quiet, nothing counted.
    reset = 1'b0;
    indep_branch(1'b1);
    mem_regwrite = 1'b1; mem_rd = 5'd5;
    #1;
    check_out("post_reset_cycle_outputs", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("post_reset_counters", 0, 0, 0);

    // Independent taken branch resolves in the same cycle.
    indep_branch(1'b1);
    #1;
    check_out("indep_taken", 1'b0, 1'b1, 2'b00, 2'b00);
    tick();
    check_cnt("indep_taken_cnt", 1, 1, 0);
    clear_pipe();
    #1;
    check_out("idle_no_branch", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();

    // ALU dependency in EX on rs1: one stall, then resolve with MEM forwarding.
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd6;
    ex_regwrite = 1'b1; ex_rd = 5'd5;
    #1;
    check_out("alu_dep_stall", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("alu_dep_stall_cnt", 1, 1, 1);
    ex_regwrite = 1'b0; ex_rd = 5'd0;
    mem_regwrite = 1'b1; mem_rd = 5'd5; branch_sel = 1'b0;
    #1;
    check_out("alu_dep_resolve", 1'b0, 1'b0, 2'b01, 2'b00);
    tick();
    check_cnt("alu_dep_cnt", 2, 1, 1);

    // Load dependency in EX on rs2: two stalls, then resolve with WB forwarding.
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd6; branch_sel = 1'b1;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd6;
    #1;
    check_out("load_dep_stall1", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd6;
    #1;
    check_out("load_dep_stall2", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("load_dep_mid_cnt", 2, 1, 3);
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = 5'd0;
    wb_regwrite = 1'b1; wb_rd = 5'd6;
    #1;
    check_out("load_dep_resolve", 1'b0, 1'b1, 2'b00, 2'b10);
    tick();
    check_cnt("load_dep_cnt", 3, 2, 3);

    // Mixed: rs1 on MEM load, rs2 on EX ALU -> exactly one stall.
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd8;
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_rd = 5'd7;
    ex_regwrite = 1'b1; ex_rd = 5'd8;
    #1;
    check_out("mixed_stall", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd8; branch_sel = 1'b1;
    wb_regwrite = 1'b1; wb_rd = 5'd7;
    mem_regwrite = 1'b1; mem_rd = 5'd8;
    #1;
    check_out("mixed_resolve", 1'b0, 1'b1, 2'b10, 2'b01);
    tick();
    check_cnt("mixed_cnt", 4, 3, 4);
    indep_branch(1'b1);
    #1;
    check_out("mixed_back_to_idle", 1'b0, 1'b1, 2'b00, 2'b00);
    tick();

    // x0 never matches, even on an EX load.
    clear_pipe();
    id_branch = 1'b1;
    ex_regwrite = 1'b1; ex_memread = 1'b1;
    mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    #1;
    check_out("x0_no_hazard", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("x0_cnt", 6, 4, 4);

    // MEM forwarding beats WB when both write the same register.
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd9; id_rs2 = 5'd10; branch_sel = 1'b1;
    mem_regwrite = 1'b1; mem_rd = 5'd9;
    wb_regwrite = 1'b1; wb_rd = 5'd9;
    #1;
    check_out("mem_over_wb", 1'b0, 1'b1, 2'b01, 2'b00);
    tick();

    // WB-only producer on rs2.
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd9;
    mem_regwrite = 1'b1; mem_rd = 5'd4;
    wb_regwrite = 1'b1; wb_rd = 5'd9;
    #1;
    check_out("wb_only_rs2", 1'b0, 1'b0, 2'b00, 2'b10);
    tick();
    check_cnt("fwd_cnt", 8, 5, 4);

    // Branch abandoned during STALL: no redirect, no count.
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd6;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd6;
    #1;
    check_out("abandon_stall_entry", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    clear_pipe();
    branch_sel = 1'b1;
    #1;
    check_out("abandon_in_stall", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("abandon_stall_cnt", 8, 5, 5);
    indep_branch(1'b1);
    #1;
    check_out("abandon_stall_idle", 1'b0, 1'b1, 2'b00, 2'b00);
    tick();

    // Branch abandoned during RESOLVE.
    clear_pipe();
    id_branch = 1'b1; id_rs1 = 5'd5;
    ex_regwrite = 1'b1; ex_rd = 5'd5;
    #1;
    check_out("abandon_res_entry", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    clear_pipe();
    branch_sel = 1'b1;
    #1;
    check_out("abandon_in_resolve", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("abandon_res_cnt", 9, 6, 6);
    indep_branch(1'b1);
    #1;
    check_out("abandon_res_idle", 1'b0, 1'b1, 2'b00, 2'b00);
    tick();
    check_cnt("abandon_res_after", 10, 7, 6);

    // Reset asserted in the STALL cycle of a load hazard.
    clear_pipe();
    id_branch = 1'b1; id_rs2 = 5'd6; branch_sel = 1'b1;
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd6;
    #1;
    check_out("rst_abort_entry", 1'b1, 1'b0, 2'b00, 2'b00);
    tick();
    reset = 1'b1;
    #1;
    check_out("rst_abort_in_stall", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("rst_abort_cnt_cleared", 0, 0, 0);
    reset = 1'b0;
    indep_branch(1'b1);
    #1;
    check_out("rst_abort_hold_cycle", 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    check_cnt("rst_abort_hold_cnt", 0, 0, 0);
    #1;
    check_out("rst_abort_first_branch", 1'b0, 1'b1, 2'b00, 2'b00);
    tick();
    check_cnt("rst_abort_first_cnt", 1, 1, 0);

    // Saturation: counters stop at all-ones.
    for (int i = 0; i < 14; i++) tick();
    check_cnt("sat_reach_max", 15, 15, 0);
    tick();
    tick();
    check_cnt("sat_hold_max", 15, 15, 0);
    clear_pipe();
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
Sequences branch resolution in the ID stage around the branch comparator. Detects RAW hazards on branch source registers and inserts 0, 1 or 2 stall cycles. Selects ID-stage operand forwarding, and drives PC redirect and IF/ID flush once the comparator's taken/not-taken result (branch_sel) is valid. Keeps saturating branch statistics counters.

Parameters:
CNT_W, 32, width of each statistics counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_branch  in  1  branch instruction present in ID
id_rs1  in  5  branch source register 1
id_rs2  in  5  branch source register 2
ex_regwrite  in  1  EX-stage instruction writes a register
ex_memread  in  1  EX-stage instruction is a load
ex_rd  in  5  EX-stage destination register
mem_regwrite  in  1  MEM-stage instruction writes a register
mem_memread  in  1  MEM-stage instruction is a load
mem_rd  in  5  MEM-stage destination register
wb_regwrite  in  1  WB-stage instruction writes a register
wb_rd  in  5  WB-stage destination register
branch_sel  in  1  comparator result, 1 = condition true
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
bubble_idex  out  1  zero ID/EX control fields
flush_ifid  out  1  squash the instruction in IF/ID
pc_sel  out  1  1 = load branch target into PC
fwd_a  out  2  rs1 source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b  out  2  rs2 source, same encoding
branch_cnt  out  CNT_W  branches resolved
taken_cnt  out  CNT_W  branches taken
stall_cnt  out  CNT_W  stall cycles inserted

Behaviour:
- Match(rs, stage) = stage_regwrite & (stage_rd == rs) & (rs != 0). x0 never matches.
- Per-operand stall need: Match(EX) & ex_memread -> 2; Match(EX) & !ex_memread -> 1; else Match(MEM) & mem_memread -> 1; else 0. Required stalls = max over rs1 and rs2.
- Forwarding is combinational in every state. Match(MEM) & !mem_memread -> 01; else Match(WB) -> 10; else 00. MEM has priority over WB.
- FSM states: IDLE, STALL, RESOLVE. Internal down-counter rem is 2 bits.
- IDLE, id_branch=0: all control outputs 0.
- IDLE, id_branch=1, need=0: resolve in the same cycle. pc_sel = flush_ifid = branch_sel. branch_cnt += 1. taken_cnt += branch_sel. Stay in IDLE.
- IDLE, id_branch=1, need>0: assert stall_pc, stall_ifid and bubble_idex this cycle. pc_sel = 0. rem <= need-1. Next state: STALL if need=2, RESOLVE if need=1. stall_cnt += 1.
- STALL: assert stall_pc, stall_ifid and bubble_idex. stall_cnt += 1. Go to RESOLVE (rem reaches 0).
- RESOLVE: no stall and no hazard re-detection. Producers have now advanced, so forwarding covers them. pc_sel = flush_ifid = branch_sel & id_branch. Counters update as in IDLE. Go to IDLE.
- id_branch deasserted in STALL or RESOLVE: abandon the branch, go to IDLE. No redirect, no count update. Outputs in that cycle are all 0.
- Stall outputs and pc_sel are never asserted together.
- Total branch latency in ID: 1 + need cycles.
- Counters saturate at all-ones and do not wrap.
- Reset: state=IDLE, rem=0, all counters 0. All outputs read 0 in the reset cycle and the cycle after. Reset asserted mid-STALL or mid-RESOLVE aborts the sequence with no redirect.

Test Plan:
- Independent branch: id_branch=1, rs1=5, rs2=6, no producer matches, branch_sel=1 -> same cycle pc_sel=1, flush_ifid=1, fwd_a=fwd_b=00; branch_cnt=1, taken_cnt=1, stall_cnt=0.
- ALU dependency: ex_regwrite=1, ex_rd=5, ex_memread=0, rs1=5 -> cycle 0: stall_pc=stall_ifid=bubble_idex=1. Cycle 1 (mem_rd=5, mem_regwrite=1): fwd_a=01, branch_sel=0, pc_sel=0. stall_cnt=1, branch_cnt=1, taken_cnt=0.
- Load dependency: ex_memread=1, ex_rd=6, rs2=6 -> two stall cycles. Third cycle has wb_rd=6, wb_regwrite=1: fwd_b=10. branch_sel=1 -> pc_sel=1. stall_cnt=2.
- Mixed operands: rs1 hits MEM load (rd=7), rs2 hits EX ALU (rd=8) -> exactly 1 stall. Resolve cycle: fwd_a=10, fwd_b=01.
- x0 and priority: rs1=0 with ex_rd=0, ex_regwrite=1 -> no stall, fwd_a=00. rs1=9 with mem_rd=9 and wb_rd=9 both writing -> fwd_a=01.
- Reset mid-operation: reset in the STALL cycle of a load hazard -> next cycle state IDLE, pc_sel=0, all counters 0. Separately, preload taken_cnt to all-ones via forced state, then issue a taken branch -> taken_cnt stays all-ones.
